uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter with an internal bit-period divider, configurable frame format and a small transmit FIFO. Producer logic writes words with a single-cycle write strobe. The block serialises each word LSB-first as start, data, optional parity and 1 or 2 stop bits. It sits between the on-chip data bus and the serial pin.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
CLK_DIV, 16, clk cycles per serial bit (>=2)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, transmit FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
data_bus  input  DATA_BITS  word to transmit
load_data  input  1  write strobe; pushes data_bus into FIFO when full=0
full  output  1  FIFO holds FIFO_DEPTH words
empty  output  1  FIFO holds no words
overflow  output  1  one-cycle pulse when load_data arrives while full=1
busy  output  1  high from first start-bit cycle through last stop-bit cycle
serial_out  output  1  serial line, idle high

Behaviour:
- Reset (rstn=0, asynchronous) forces:
  - Outputs: serial_out=1, busy=0, full=0, empty=1, overflow=0.
  - Internal state: FSM=IDLE, FIFO pointers/count=0, divider=0, bit counter=0.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- Clock and reset:
  - Single clock domain; no combinational path from inputs to serial_out.
  - All outputs are registered except full/empty, which are decoded from the registered count.
- FIFO:
  - Write accepted on an edge where load_data=1 and full=0.
  - A write while full=1 is dropped and overflow pulses, even if the FSM pops on the same edge.
  - Simultaneous pop and accepted write leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when empty=0. On that edge: pop the head word into the shift register, drive serial_out=0, set busy=1.
  - Latency: a write to an empty FIFO at edge k gives serial_out=0 from edge k+1.
  - Each state holds for exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1 and advances the bit on terminal count.
  - START -> DATA.
  - DATA: shifts out DATA_BITS bits, LSB first. Then -> PARITY if PARITY_EN, else -> STOP.
  - PARITY: drives the XOR of all data bits, inverted if PARITY_ODD. Parity is computed at pop time.
  - STOP: drives 1 for STOP_BITS*CLK_DIV cycles.
  - At the end of STOP: if empty=0, go directly to START with the next pop (no idle gap between frames). Otherwise go to IDLE and set busy=0.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLK_DIV cycles.
- data_bus is sampled only at the write edge; later changes do not affect queued words.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - width helper function clog2;
  - default parameter constants, for reuse by the matching receiver.
- Sub-module uart_tx_fifo (parametrised by width and depth; outputs full/empty/count; push/pop interface) keeps buffering separate from the serialiser FSM.

Test Plan:
- 8N1, CLK_DIV=4: write 0xA5 into an idle block -> serial_out low from the next edge; bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for exactly 40 cycles; then idle high.
- PARITY_EN=1, PARITY_ODD=0, CLK_DIV=4: write 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame length 44 cycles.
- Write 0x11, 0x22, 0x33 on consecutive cycles -> three frames back-to-back; the start bit of frame n+1 immediately follows the last stop cycle of frame n; busy stays high 120 cycles; empty rises at the third pop.
- FIFO_DEPTH=4: write 6 words on consecutive cycles into an idle block:
  - first word is popped after 1 cycle, so words 1-5 are accepted;
  - full=1 after the 5th write;
  - 6th write gives an overflow pulse and is dropped;
  - exactly 5 frames are emitted.
- STOP_BITS=2, DATA_BITS=7: write 0x7F -> frame 0,1x7,1,1 with a stop period of 2*CLK_DIV cycles; total length 10*CLK_DIV.
- Assert rstn=0 mid-DATA with 2 words queued -> serial_out=1, busy=0, empty=1 with no clock edge needed; after release no frame is sent until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, width helper,
// parity helper and default frame constants reused by the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_CLK_DIV       = 16;
  localparam int UART_PARITY_EN     = 0;
  localparam int UART_PARITY_ODD    = 0;
  localparam int UART_STOP_BITS     = 1;
  localparam int UART_FIFO_DEPTH    = 4;
  localparam int UART_MAX_DATA_BITS = 9;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Even parity of the payload, flipped for odd parity; unused upper bits must be zero.
  function automatic logic calc_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous transmit FIFO: power-of-two depth, registered count,
// full/empty decoded from the count. Pushes while full are ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status decode and handshake qualification.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    push_ok_s = push & ~full_s;
    pop_ok_s  = pop & ~empty_s;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage; cleared on reset so a stale word can never be replayed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised LSB-first as
// start, data, optional parity and 1 or 2 stop bits, with back-to-back frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int CLK_DIV    = UART_CLK_DIV,
  parameter int PARITY_EN  = UART_PARITY_EN,
  parameter int PARITY_ODD = UART_PARITY_ODD,
  parameter int STOP_BITS  = UART_STOP_BITS,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] data_bus,
  input  logic                 load_data,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic                 serial_out
);

  localparam int DIV_W = clog2(CLK_DIV);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);

  uart_state_e          state_r,  state_s;
  logic [DIV_W-1:0]     div_r,    div_s;
  logic [BIT_W-1:0]     bit_r,    bit_s;
  logic [DATA_BITS-1:0] shift_r,  shift_s;
  logic                 parity_r, parity_s;
  logic                 serial_r, serial_s;
  logic                 busy_r,   busy_s;
  logic                 overflow_r;
  logic                 pop_s;
  logic                 tc_s;
  logic                 have_word_s;
  logic                 head_parity_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;
  logic [CNT_W-1:0]     fifo_count_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (load_data),
    .wdata (data_bus),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Next-state and next-output logic of the serialiser.
  always_comb begin
    state_s       = state_r;
    div_s         = div_r;
    bit_s         = bit_r;
    shift_s       = shift_r;
    parity_s      = parity_r;
    serial_s      = serial_r;
    busy_s        = busy_r;
    pop_s         = 1'b0;
    tc_s          = (div_r == DIV_LAST);
    have_word_s   = (fifo_count_s != {CNT_W{1'b0}});
    head_parity_s = calc_parity(UART_MAX_DATA_BITS'(fifo_rdata_s), ODD_SEL);

    if (state_r == IDLE || tc_s) begin
      div_s = {DIV_W{1'b0}};
    end else begin
      div_s = div_r + DIV_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (have_word_s) begin
          pop_s    = 1'b1;
          shift_s  = fifo_rdata_s;
          parity_s = head_parity_s;
          state_s  = START;
          serial_s = 1'b0;
          busy_s   = 1'b1;
        end else begin
          serial_s = 1'b1;
          busy_s   = 1'b0;
        end
      end
      START: begin
        if (tc_s) begin
          state_s  = DATA;
          bit_s    = {BIT_W{1'b0}};
          serial_s = shift_r[0];
          shift_s  = shift_r >> 1'b1;
        end else begin
          serial_s = 1'b0;
        end
      end
      DATA: begin
        if (tc_s && bit_r == DATA_LAST) begin
          bit_s = {BIT_W{1'b0}};
          if (PARITY_EN != 0) begin
            state_s  = PARITY;
            serial_s = parity_r;
          end else begin
            state_s  = STOP;
            serial_s = 1'b1;
          end
        end else if (tc_s) begin
          bit_s    = bit_r + BIT_W'(1);
          serial_s = shift_r[0];
          shift_s  = shift_r >> 1'b1;
        end else begin
          serial_s = serial_r;
        end
      end
      PARITY: begin
        if (tc_s) begin
          state_s  = STOP;
          bit_s    = {BIT_W{1'b0}};
          serial_s = 1'b1;
        end else begin
          serial_s = parity_r;
        end
      end
      STOP: begin
        // The next queued word starts on the edge that ends the last stop bit.
        if (tc_s && bit_r == STOP_LAST && have_word_s) begin
          pop_s    = 1'b1;
          shift_s  = fifo_rdata_s;
          parity_s = head_parity_s;
          state_s  = START;
          serial_s = 1'b0;
          busy_s   = 1'b1;
        end else if (tc_s && bit_r == STOP_LAST) begin
          state_s  = IDLE;
          serial_s = 1'b1;
          busy_s   = 1'b0;
        end else if (tc_s) begin
          bit_s    = bit_r + BIT_W'(1);
          serial_s = 1'b1;
        end else begin
          serial_s = 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
        div_s    = {DIV_W{1'b0}};
        bit_s    = {BIT_W{1'b0}};
        serial_s = 1'b1;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Serialiser state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      div_r      <= {DIV_W{1'b0}};
      bit_r      <= {BIT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      parity_r   <= 1'b0;
      serial_r   <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      parity_r   <= parity_s;
      serial_r   <= serial_s;
      busy_r     <= busy_s;
      overflow_r <= load_data & fifo_full_s;
    end
  end

  assign full       = fifo_full_s;
  assign empty      = fifo_empty_s;
  assign overflow   = overflow_r;
  assign busy       = busy_r;
  assign serial_out = serial_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four frame formats checked cycle by
// cycle against a queue-based model of the FIFO and the serial waveform.
module tb_uart_tx_param;

  localparam int N = 4;
  localparam int DBITS [N] = '{8, 8, 8, 7};
  localparam int CDIV  [N] = '{4, 4, 4, 3};
  localparam int PEN   [N] = '{0, 1, 1, 0};
  localparam int PODD  [N] = '{0, 0, 1, 0};
  localparam int STOPS [N] = '{1, 1, 1, 2};
  localparam int DEPTH [N] = '{4, 2, 4, 4};

  logic       clk = 1'b0;
  logic       rstn;
  logic       ld [N];
  logic [7:0] db [3];
  logic [6:0] db7;
  logic       so [N];
  logic       bz [N];
  logic       fl [N];
  logic       em [N];
  logic       ov [N];

  int errors = 0;
  int checks = 0;

  logic [7:0] mq [$];
  bit         lq [$];
  logic       e_line, e_busy, e_empty, e_full, e_ovf;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(DBITS[0]), .CLK_DIV(CDIV[0]), .PARITY_EN(PEN[0]),
                  .PARITY_ODD(PODD[0]), .STOP_BITS(STOPS[0]), .FIFO_DEPTH(DEPTH[0])) u0 (
    .clk(clk), .rstn(rstn), .data_bus(db[0]), .load_data(ld[0]), .full(fl[0]),
    .empty(em[0]), .overflow(ov[0]), .busy(bz[0]), .serial_out(so[0]));

  uart_tx_param #(.DATA_BITS(DBITS[1]), .CLK_DIV(CDIV[1]), .PARITY_EN(PEN[1]),
                  .PARITY_ODD(PODD[1]), .STOP_BITS(STOPS[1]), .FIFO_DEPTH(DEPTH[1])) u1 (
    .clk(clk), .rstn(rstn), .data_bus(db[1]), .load_data(ld[1]), .full(fl[1]),
    .empty(em[1]), .overflow(ov[1]), .busy(bz[1]), .serial_out(so[1]));

  uart_tx_param #(.DATA_BITS(DBITS[2]), .CLK_DIV(CDIV[2]), .PARITY_EN(PEN[2]),
                  .PARITY_ODD(PODD[2]), .STOP_BITS(STOPS[2]), .FIFO_DEPTH(DEPTH[2])) u2 (
    .clk(clk), .rstn(rstn), .data_bus(db[2]), .load_data(ld[2]), .full(fl[2]),
    .empty(em[2]), .overflow(ov[2]), .busy(bz[2]), .serial_out(so[2]));

  uart_tx_param #(.DATA_BITS(DBITS[3]), .CLK_DIV(CDIV[3]), .PARITY_EN(PEN[3]),
                  .PARITY_ODD(PODD[3]), .STOP_BITS(STOPS[3]), .FIFO_DEPTH(DEPTH[3])) u3 (
    .clk(clk), .rstn(rstn), .data_bus(db7), .load_data(ld[3]), .full(fl[3]),
    .empty(em[3]), .overflow(ov[3]), .busy(bz[3]), .serial_out(so[3]));

  task automatic chk(input string tag, input int inst, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s u%0d t=%0t got=%b exp=%b", tag, inst, $time, got, exp);
    end
  endtask

  function automatic void push_bits(input int inst, input bit b);
    for (int k = 0; k < CDIV[inst]; k++) lq.push_back(b);
  endfunction

  // Expected line waveform of one frame, built from the frame format rules.
  function automatic void add_frame(input int inst, input logic [7:0] w);
    int ones;
    ones = 0;
    push_bits(inst, 1'b0);
    for (int i = 0; i < DBITS[inst]; i++) begin
      push_bits(inst, w[i]);
      ones += int'(w[i]);
    end
    if (PEN[inst] != 0) push_bits(inst, bit'((ones % 2 == 1) ^ (PODD[inst] != 0)));
    for (int s = 0; s < STOPS[inst]; s++) push_bits(inst, 1'b1);
  endfunction

  task automatic drive(input int inst, input bit wr, input logic [7:0] d);
    ld[inst] = wr;
    if (inst < 3) db[inst] = d;
    else db7 = d[6:0];
  endtask

  // One clock: optional write, model update, then compare all outputs.
  task automatic step(input int inst, input bit wr, input logic [7:0] d);
    int  cnt0;
    logic [7:0] w;
    drive(inst, wr, d);
    @(posedge clk);
    cnt0  = mq.size();
    e_ovf = wr && (cnt0 == DEPTH[inst]);
    if (lq.size() == 0 && cnt0 > 0) begin
      w = mq.pop_front();
      add_frame(inst, w);
    end
    if (wr && cnt0 < DEPTH[inst]) mq.push_back(d & 8'((1 << DBITS[inst]) - 1));
    if (lq.size() > 0) begin
      e_line = lq.pop_front();
      e_busy = 1'b1;
    end else begin
      e_line = 1'b1;
      e_busy = 1'b0;
    end
    e_empty = (mq.size() == 0);
    e_full  = (mq.size() == DEPTH[inst]);
    #1;
    drive(inst, 1'b0, d);
    chk("serial_out", inst, so[inst], e_line);
    chk("busy", inst, bz[inst], e_busy);
    chk("empty", inst, em[inst], e_empty);
    chk("full", inst, fl[inst], e_full);
    chk("overflow", inst, ov[inst], e_ovf);
  endtask

  task automatic burst(input int inst, input logic [7:0] words [$], input int tail);
    foreach (words[i]) step(inst, 1'b1, words[i]);
    for (int c = 0; c < tail; c++) step(inst, 1'b0, 8'h00);
  endtask

  task automatic drain(input int inst);
    for (int c = 0; c < 2000 && (lq.size() > 0 || mq.size() > 0); c++) step(inst, 1'b0, 8'h00);
    step(inst, 1'b0, 8'h00);
  endtask

  task automatic random_run(input int inst, input int cycles);
    for (int c = 0; c < cycles; c++) step(inst, ($urandom_range(9, 0) == 0), 8'($urandom));
    drain(inst);
  endtask

  initial begin
    logic [7:0] wl [$];
    for (int i = 0; i < N; i++) ld[i] = 1'b0;
    for (int i = 0; i < 3; i++) db[i] = 8'h00;
    db7  = 7'h00;
    rstn = 1'b0;
    #12;
    for (int i = 0; i < N; i++) begin
      chk("rst_serial", i, so[i], 1'b1);
      chk("rst_busy", i, bz[i], 1'b0);
      chk("rst_empty", i, em[i], 1'b1);
      chk("rst_full", i, fl[i], 1'b0);
      chk("rst_ovf", i, ov[i], 1'b0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // 8N1 single word, then three back-to-back frames, then FIFO overflow.
    wl = '{8'hA5};                                   burst(0, wl, 50);
    wl = '{8'h11, 8'h22, 8'h33};                     burst(0, wl, 130);
    wl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; burst(0, wl, 220);
    drain(0);
    // Even and odd parity on 0x07, 7-bit two-stop frame on 0x7F.
    wl = '{8'h07}; burst(1, wl, 55); drain(1);
    wl = '{8'h07}; burst(2, wl, 55); drain(2);
    wl = '{8'h7F}; burst(3, wl, 40); drain(3);
    // Random traffic, including overflow into the depth-2 FIFO.
    random_run(1, 400);
    random_run(3, 300);
    random_run(0, 300);

    // Asynchronous reset in the middle of a data bit with two words queued.
    wl = '{8'hC3, 8'h3C, 8'h5A}; burst(0, wl, 12);
    rstn = 1'b0;
    #1;
    chk("midrst_serial", 0, so[0], 1'b1);
    chk("midrst_busy", 0, bz[0], 1'b0);
    chk("midrst_empty", 0, em[0], 1'b1);
    chk("midrst_full", 0, fl[0], 1'b0);
    mq.delete();
    lq.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 60; c++) step(0, 1'b0, 8'h00);
    wl = '{8'h96}; burst(0, wl, 45);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
